// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file types and constants
package regfile_pkg;

  localparam int REG_W   = 64;
  localparam int NREG    = 32;
  localparam int RADDR_W = 5;

  localparam logic [RADDR_W-1:0] XZR = 5'd31;

  typedef struct packed {
    logic [RADDR_W-1:0] rd;
    logic [REG_W-1:0]   data;
  } wb_entry_t;

endpackage

// File: rtl/wbq_fifo.sv
// rtl/wbq_fifo.sv - circular writeback buffer, up to two pushes and one pop per cycle
module wbq_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push0,
  input  wb_entry_t                din0,
  input  logic                     push1,
  input  wb_entry_t                din1,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output wb_entry_t                head_entry,
  output wb_entry_t                entries [DEPTH],
  output logic [DEPTH-1:0]         valid
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t       mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      tail  <= tail + PW'(push0) + PW'(push1);
      if (pop) head <= head + PW'(1);
      count <= count + CW'(push0) + CW'(push1) - CW'(pop);
    end
  end

  // Storage is not reset; only entries below count are ever observed.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (push0) mem[tail] <= din0;
      if (push1) mem[push0 ? tail + PW'(1) : tail] <= din1;
    end
  end

  assign head_entry = mem[head];

  // Age-ordered view: index 0 is the oldest entry, higher indices are newer.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries[i] = mem[head + PW'(i)];
      valid[i]   = (CW'(i) < count);
    end
  end

endmodule

// File: rtl/regfile_wb_queue.sv
// rtl/regfile_wb_queue.sv - writeback queue draining ALU/MEM results onto the regfile write port
module regfile_wb_queue
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 alu_valid,
  input  logic [RADDR_W-1:0]   alu_rd,
  input  logic [WIDTH-1:0]     alu_data,
  output logic                 alu_ready,
  input  logic                 mem_valid,
  input  logic [RADDR_W-1:0]   mem_rd,
  input  logic [WIDTH-1:0]     mem_data,
  output logic                 mem_ready,
  output logic                 RegWrite,
  output logic [RADDR_W-1:0]   WriteRegister,
  output logic [WIDTH-1:0]     WriteData,
  input  logic [RADDR_W-1:0]   fwd_addr1,
  input  logic [RADDR_W-1:0]   fwd_addr2,
  output logic                 fwd_hit1,
  output logic                 fwd_hit2,
  output logic [WIDTH-1:0]     fwd_data1,
  output logic [WIDTH-1:0]     fwd_data2,
  output logic                 empty,
  output logic                 full
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]       count;
  logic [CW-1:0]       free;
  logic                alu_acc, mem_acc;
  logic                push0, push1, pop;
  wb_entry_t           din0, din1, head_entry;
  wb_entry_t           entries [DEPTH];
  logic [DEPTH-1:0]    valid;

  // Readiness looks only at the registered count; the pop this cycle is not credited.
  assign free      = CW'(DEPTH) - count;
  assign alu_ready = (free >= CW'(1));
  assign mem_ready = (free >= CW'(2)) || ((free == CW'(1)) && !alu_valid);

  assign alu_acc = alu_valid && alu_ready;
  assign mem_acc = mem_valid && mem_ready;
  assign push0   = alu_acc && (alu_rd != XZR);
  assign push1   = mem_acc && (mem_rd != XZR);
  assign din0    = '{rd: alu_rd, data: REG_W'(alu_data)};
  assign din1    = '{rd: mem_rd, data: REG_W'(mem_data)};
  assign pop     = (count != '0);

  wbq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push0      (push0),
    .din0       (din0),
    .push1      (push1),
    .din1       (din1),
    .pop        (pop),
    .count      (count),
    .head_entry (head_entry),
    .entries    (entries),
    .valid      (valid)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
    end else if (pop) begin
      RegWrite      <= 1'b1;
      WriteRegister <= head_entry.rd;
      WriteData     <= WIDTH'(head_entry.data);
    end else begin
      RegWrite      <= 1'b0;
    end
  end

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  logic [RADDR_W-1:0] fa [2];
  logic [1:0]         fh;
  logic [WIDTH-1:0]   fd [2];

  assign fa[0] = fwd_addr1;
  assign fa[1] = fwd_addr2;

  // The output register is the oldest candidate; later queue entries override it.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      fh[p] = 1'b0;
      fd[p] = '0;
      if (fa[p] != XZR) begin
        if (RegWrite && (WriteRegister == fa[p])) begin
          fh[p] = 1'b1;
          fd[p] = WriteData;
        end
        for (int i = 0; i < DEPTH; i++) begin
          if (valid[i] && (entries[i].rd == fa[p])) begin
            fh[p] = 1'b1;
            fd[p] = WIDTH'(entries[i].data);
          end
        end
      end
    end
  end

  assign fwd_hit1  = fh[0];
  assign fwd_hit2  = fh[1];
  assign fwd_data1 = fd[0];
  assign fwd_data2 = fd[1];

endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb/tb_regfile_wb_queue.sv - scoreboard bench for regfile_wb_queue
module tb_regfile_wb_queue;

  localparam int DEPTH = 4;
  localparam int WIDTH = 64;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              alu_valid = 1'b0;
  logic [4:0]        alu_rd = '0;
  logic [WIDTH-1:0]  alu_data = '0;
  logic              alu_ready;
  logic              mem_valid = 1'b0;
  logic [4:0]        mem_rd = '0;
  logic [WIDTH-1:0]  mem_data = '0;
  logic              mem_ready;
  logic              RegWrite;
  logic [4:0]        WriteRegister;
  logic [WIDTH-1:0]  WriteData;
  logic [4:0]        fwd_addr1 = '0;
  logic [4:0]        fwd_addr2 = '0;
  logic              fwd_hit1, fwd_hit2;
  logic [WIDTH-1:0]  fwd_data1, fwd_data2;
  logic              empty, full;

  always #5 clk = ~clk;

  regfile_wb_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .alu_valid     (alu_valid),
    .alu_rd        (alu_rd),
    .alu_data      (alu_data),
    .alu_ready     (alu_ready),
    .mem_valid     (mem_valid),
    .mem_rd        (mem_rd),
    .mem_data      (mem_data),
    .mem_ready     (mem_ready),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .fwd_addr1     (fwd_addr1),
    .fwd_addr2     (fwd_addr2),
    .fwd_hit1      (fwd_hit1),
    .fwd_hit2      (fwd_hit2),
    .fwd_data1     (fwd_data1),
    .fwd_data2     (fwd_data2),
    .empty         (empty),
    .full          (full)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
  } item_t;

  item_t mq[$];
  item_t exp_wr[$];
  logic  out_valid = 1'b0;
  item_t out_reg;
  int    n_checks = 0;
  int    n_errors = 0;
  bit    mon_en = 1'b0;

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [64:0] model_fwd(input logic [4:0] a);
    logic [64:0] r;
    r = '0;
    if (a != 5'd31) begin
      if (out_valid && out_reg.rd == a) r = {1'b1, out_reg.data};
      foreach (mq[i]) if (mq[i].rd == a) r = {1'b1, mq[i].data};
    end
    return r;
  endfunction

  function automatic logic [4:0] rnd_rd();
    if ($urandom_range(0, 9) == 0) return 5'd31;
    return 5'($urandom_range(0, 7));
  endfunction

  function automatic logic [63:0] rnd_data();
    return {$urandom(), $urandom()};
  endfunction

  task automatic step(input logic av, input logic [4:0] ard, input logic [63:0] ad,
                      input logic mv, input logic [4:0] mrd, input logic [63:0] md,
                      input logic [4:0] f1, input logic [4:0] f2);
    int          free;
    logic        ear, emr;
    logic [64:0] e1, e2;
    item_t       it;
    @(negedge clk);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    fwd_addr1 = f1; fwd_addr2 = f2;
    #1;
    free = DEPTH - mq.size();
    ear  = (free >= 1);
    emr  = (free >= 2) || (free == 1 && !av);
    check1("alu_ready", alu_ready, ear);
    check1("mem_ready", mem_ready, emr);
    check1("empty", empty, mq.size() == 0);
    check1("full", full, mq.size() == DEPTH);
    e1 = model_fwd(f1);
    e2 = model_fwd(f2);
    check1("fwd_hit1", fwd_hit1, e1[64]);
    check64("fwd_data1", fwd_data1, e1[63:0]);
    check1("fwd_hit2", fwd_hit2, e2[64]);
    check64("fwd_data2", fwd_data2, e2[63:0]);
    @(posedge clk);
    if (mq.size() > 0) begin
      it = mq.pop_front();
      exp_wr.push_back(it);
      out_valid = 1'b1;
      out_reg   = it;
    end else begin
      out_valid = 1'b0;
    end
    if (av && ear && ard != 5'd31) mq.push_back('{ard, ad});
    if (mv && emr && mrd != 5'd31) mq.push_back('{mrd, md});
  endtask

  task automatic idle(input logic [4:0] f1);
    step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, f1, rnd_rd());
  endtask

  task automatic do_reset(input logic av);
    @(negedge clk);
    reset_n = 1'b0;
    alu_valid = av; alu_rd = 5'd3; alu_data = 64'h55;
    mem_valid = 1'b0;
    @(posedge clk);
    mq.delete();
    out_valid = 1'b0;
    #1;
    check1("rst_regwrite", RegWrite, 1'b0);
    check64("rst_wreg", 64'(WriteRegister), 64'd0);
    check64("rst_wdata", WriteData, 64'd0);
    check1("rst_empty", empty, 1'b1);
    check1("rst_full", full, 1'b0);
    check1("rst_alu_ready", alu_ready, 1'b1);
    reset_n = 1'b1;
  endtask

  initial begin : monitor
    item_t it;
    wait (mon_en);
    forever begin
      @(negedge clk);
      check1("regwrite", RegWrite, exp_wr.size() != 0);
      if (RegWrite && exp_wr.size() != 0) begin
        it = exp_wr.pop_front();
        check64("write_register", 64'(WriteRegister), 64'(it.rd));
        check64("write_data", WriteData, it.data);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin : driver
    do_reset(1'b1);
    mon_en = 1'b1;

    step(1'b1, 5'd3, 64'h11, 1'b0, 5'd0, 64'd0, 5'd3, 5'd0);
    repeat (3) idle(5'd3);

    step(1'b1, 5'd1, 64'hA, 1'b1, 5'd2, 64'hB, 5'd1, 5'd2);
    repeat (3) idle(5'd2);

    repeat (6) step(1'b1, 5'($urandom_range(0, 7)), rnd_data(),
                    1'b1, 5'($urandom_range(0, 7)), rnd_data(), rnd_rd(), rnd_rd());
    repeat (4) idle(rnd_rd());

    step(1'b0, 5'd0, 64'd0, 1'b1, 5'd31, 64'hDEAD, 5'd31, 5'd31);
    repeat (2) idle(5'd31);

    step(1'b1, 5'd5, 64'h1, 1'b0, 5'd0, 64'd0, 5'd5, 5'd0);
    step(1'b1, 5'd5, 64'h2, 1'b0, 5'd0, 64'd0, 5'd5, 5'd0);
    repeat (3) idle(5'd5);

    step(1'b1, 5'd8, 64'h81, 1'b1, 5'd9, 64'h91, 5'd8, 5'd9);
    step(1'b1, 5'd10, 64'ha1, 1'b1, 5'd11, 64'hb1, 5'd10, 5'd11);
    do_reset(1'b0);
    step(1'b1, 5'd7, 64'h77, 1'b0, 5'd0, 64'd0, 5'd7, 5'd10);
    repeat (3) idle(5'd7);

    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset(1'($urandom_range(0, 1)));
      end else begin
        step(1'($urandom_range(0, 3) != 0), rnd_rd(), rnd_data(),
             1'($urandom_range(0, 3) != 0), rnd_rd(), rnd_data(), rnd_rd(), rnd_rd());
      end
    end

    repeat (8) idle(rnd_rd());
    check64("leftover_writes", 64'(exp_wr.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
